// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle shared by the core requesters, the arbiter and Memory.
//                slave  - arbiter view (consumes requests and read data,
//                         produces ready/response and the Memory drive).
//                master - environment view (core requesters plus Memory).
//  Signals     : hold; IF request/response (if_req_*, if_resp_*);
//                D request/response (d_req_*, d_resp_*);
//                Memory drive (mem_address, mem_data, mem_write_mode,
//                mem_read_mode, mem_unsigned) and mem_rdata.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic        hold;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [2:0]  d_req_write_mode;
    logic [2:0]  d_req_read_mode;
    logic        d_req_unsigned;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic [2:0]  mem_write_mode;
    logic [2:0]  mem_read_mode;
    logic        mem_unsigned;
    logic [31:0] mem_rdata;

    modport slave (
        input  hold, if_req_valid, if_req_addr,
        input  d_req_valid, d_req_addr, d_req_wdata, d_req_write_mode,
        input  d_req_read_mode, d_req_unsigned, mem_rdata,
        output if_req_ready, if_resp_valid, if_resp_data,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_address, mem_data, mem_write_mode, mem_read_mode, mem_unsigned
    );

    modport master (
        output hold, if_req_valid, if_req_addr,
        output d_req_valid, d_req_addr, d_req_wdata, d_req_write_mode,
        output d_req_read_mode, d_req_unsigned, mem_rdata,
        input  if_req_ready, if_resp_valid, if_resp_data,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_address, mem_data, mem_write_mode, mem_read_mode, mem_unsigned
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single Memory data port between instruction
//                fetch (IF) and load/store (D). Per-cycle combinational
//                arbitration (D preferred, IF forced after STARVE_LIMIT
//                denied cycles), one-deep issue stage driving Memory, and a
//                response stage returning data 2 cycles after the handshake.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - mem_port_arbiter_if.slave (requests, responses,
//                       Memory drive and read data)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mem_port_arbiter_if.slave       bus
);
    localparam logic [2:0] c_MODE_NONE = 3'd0;
    localparam logic [2:0] c_MODE_WORD = 3'd3;
    localparam int         c_CW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE_IF = 2'd1,
        S_ISSUE_D  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [c_CW-1:0] r_starve;
    logic            w_if_grant;
    logic            w_d_grant;

    logic [31:0]     r_if_addr;
    logic [31:0]     r_d_addr;
    logic [31:0]     r_d_wdata;
    logic [2:0]      r_d_wmode;
    logic [2:0]      r_d_rmode;
    logic            r_d_uns;

    logic            r_if_resp_valid;
    logic [31:0]     r_if_resp_data;
    logic            r_d_resp_valid;
    logic [31:0]     r_d_resp_data;

    logic [31:0]     w_mem_address;
    logic [31:0]     w_mem_data;
    logic [2:0]      w_mem_wmode;
    logic [2:0]      w_mem_rmode;
    logic            w_mem_uns;

    // Arbitration and next issue state. A grant is the handshake, since
    // the ready returned is only ever raised for a valid requester.
    always_comb begin
        w_if_grant   = 1'b0;
        w_d_grant    = 1'b0;
        w_next_state = S_IDLE;
        if (!rst && !bus.hold) begin
            if (bus.if_req_valid && (r_starve == c_LIMIT || !bus.d_req_valid)) begin
                w_if_grant = 1'b1;
            end else if (bus.d_req_valid) begin
                w_d_grant = 1'b1;
            end
        end
        if (w_if_grant) begin
            w_next_state = S_ISSUE_IF;
        end else if (w_d_grant) begin
            w_next_state = S_ISSUE_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Starvation counter: counts consecutive denied-while-valid IF cycles,
    // including cycles lost to hold.
    always_ff @(posedge clk) begin
        if (rst || !bus.if_req_valid || w_if_grant) begin
            r_starve <= '0;
        end else if (r_starve != c_LIMIT) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_addr <= '0;
            r_d_addr  <= '0;
            r_d_wdata <= '0;
            r_d_wmode <= c_MODE_NONE;
            r_d_rmode <= c_MODE_NONE;
            r_d_uns   <= 1'b0;
        end else begin
            if (w_if_grant) begin
                r_if_addr <= bus.if_req_addr;
            end
            if (w_d_grant) begin
                r_d_addr  <= bus.d_req_addr;
                r_d_wdata <= bus.d_req_wdata;
                r_d_wmode <= bus.d_req_write_mode;
                r_d_rmode <= bus.d_req_read_mode;
                r_d_uns   <= bus.d_req_unsigned;
            end
        end
    end

    // Memory drive. Gating on rst keeps a store sitting in the issue stage
    // from committing while reset is asserted.
    always_comb begin
        w_mem_address = '0;
        w_mem_data    = '0;
        w_mem_wmode   = c_MODE_NONE;
        w_mem_rmode   = c_MODE_NONE;
        w_mem_uns     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_ISSUE_IF: begin
                    w_mem_address = r_if_addr & 32'hFFFF_FFFC;
                    w_mem_rmode   = c_MODE_WORD;
                end
                S_ISSUE_D: begin
                    w_mem_address = r_d_addr;
                    w_mem_data    = r_d_wdata;
                    w_mem_wmode   = r_d_wmode;
                    w_mem_rmode   = r_d_rmode;
                    w_mem_uns     = r_d_uns;
                end
                default: ;
            endcase
        end
    end

    // Response stage: capture read data at the end of the issue cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_resp_valid <= 1'b0;
            r_if_resp_data  <= '0;
            r_d_resp_valid  <= 1'b0;
            r_d_resp_data   <= '0;
        end else begin
            r_if_resp_valid <= (r_state == S_ISSUE_IF);
            r_d_resp_valid  <= (r_state == S_ISSUE_D);
            if (r_state == S_ISSUE_IF) begin
                r_if_resp_data <= bus.mem_rdata;
            end
            if (r_state == S_ISSUE_D) begin
                r_d_resp_data <= (r_d_rmode != c_MODE_NONE) ? bus.mem_rdata : 32'd0;
            end
        end
    end

    assign bus.if_req_ready   = w_if_grant;
    assign bus.d_req_ready    = w_d_grant;
    assign bus.if_resp_valid  = r_if_resp_valid;
    assign bus.if_resp_data   = r_if_resp_data;
    assign bus.d_resp_valid   = r_d_resp_valid;
    assign bus.d_resp_data    = r_d_resp_data;
    assign bus.mem_address    = w_mem_address;
    assign bus.mem_data       = w_mem_data;
    assign bus.mem_write_mode = w_mem_wmode;
    assign bus.mem_read_mode  = w_mem_rmode;
    assign bus.mem_unsigned   = w_mem_uns;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Contains a byte
//                Memory model on the bus and a transaction-level reference
//                (grant rules, queue of issued ops, shadow memory).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int         STARVE_LIMIT = 4;
    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] BYTE = 3'd1;
    localparam logic [2:0] HALF = 3'd2;
    localparam logic [2:0] WORD = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] tb_mem  [256];
    logic [7:0] ref_mem [256];

    function automatic logic [31:0] rd(input logic [7:0] b0, b1, b2, b3,
                                       input logic [2:0] mode, input logic uns);
        case (mode)
            BYTE:    return uns ? {24'd0, b0} : {{24{b0[7]}}, b0};
            HALF:    return uns ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            WORD:    return {b3, b2, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] mode);
        case (mode)
            BYTE:    return 1;
            HALF:    return 2;
            WORD:    return 4;
            default: return 0;
        endcase
    endfunction

    // Memory: combinational read, write committed at the clock edge.
    logic [7:0] ma;
    assign ma = bus.mem_address[7:0];
    assign bus.mem_rdata = rd(tb_mem[ma], tb_mem[ma + 8'd1], tb_mem[ma + 8'd2],
                              tb_mem[ma + 8'd3], bus.mem_read_mode, bus.mem_unsigned);

    typedef struct {
        logic        is_if;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  wm;
        logic [2:0]  rm;
        logic        uns;
        int          cyc;
    } op_t;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    op_t         pend[$];
    rsp_t        resq[$];
    int          m_starve = 0;
    logic [31:0] last_if = 0;
    logic [31:0] last_d  = 0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_chk  = 0;
    logic [2:0]  pw_mode = NONE;
    logic [31:0] pw_addr = 0;
    logic [31:0] pw_data = 0;
    logic        obs_if_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: commit the Memory write seen last cycle, drive the
    // inputs, then compare all outputs against the reference at negedge.
    task automatic step(input logic r, h, iv, input logic [31:0] ia,
                        input logic dv, input logic [31:0] da, dw,
                        input logic [2:0] wm, rm, input logic u);
        logic        e_if, e_d, ev;
        logic [31:0] ea, ed, edata, rdat;
        logic [2:0]  ewm, erm;
        logic        eu;
        op_t         o;
        rsp_t        rr;
        @(posedge clk);
        #1;
        for (int k = 0; k < nbytes(pw_mode); k++)
            tb_mem[8'(pw_addr[7:0] + k)] = pw_data[8*k +: 8];
        rst                  = r;
        bus.hold             = h;
        bus.if_req_valid     = iv;
        bus.if_req_addr      = ia;
        bus.d_req_valid      = dv;
        bus.d_req_addr       = da;
        bus.d_req_wdata      = dw;
        bus.d_req_write_mode = wm;
        bus.d_req_read_mode  = rm;
        bus.d_req_unsigned   = u;
        @(negedge clk);

        e_if = !r && !h && iv && (m_starve == STARVE_LIMIT || !dv);
        e_d  = !r && !h && dv && !e_if;
        chk("if_ready", {31'd0, bus.if_req_ready}, {31'd0, e_if});
        chk("d_ready",  {31'd0, bus.d_req_ready},  {31'd0, e_d});
        obs_if_rdy = bus.if_req_ready;

        ea = 0; ed = 0; ewm = NONE; erm = NONE; eu = 0;
        if (!r && pend.size() > 0 && pend[0].cyc == cyc) begin
            o = pend[0];
            if (o.is_if) begin
                ea  = {o.addr[31:2], 2'b00};
                erm = WORD;
            end else begin
                ea = o.addr; ed = o.wdata; ewm = o.wm; erm = o.rm; eu = o.uns;
            end
        end
        chk("mem_wmode", {29'd0, bus.mem_write_mode}, {29'd0, ewm});
        if (!r) begin
            chk("mem_addr",  bus.mem_address, ea);
            chk("mem_data",  bus.mem_data, ed);
            chk("mem_rmode", {29'd0, bus.mem_read_mode}, {29'd0, erm});
            chk("mem_uns",   {31'd0, bus.mem_unsigned}, {31'd0, eu});

            ev    = resq.size() > 0 && resq[0].cyc == cyc && resq[0].is_if;
            edata = ev ? resq[0].data : last_if;
            chk("if_resp_valid", {31'd0, bus.if_resp_valid}, {31'd0, ev});
            chk("if_resp_data",  bus.if_resp_data, edata);
            ev    = resq.size() > 0 && resq[0].cyc == cyc && !resq[0].is_if;
            edata = ev ? resq[0].data : last_d;
            chk("d_resp_valid", {31'd0, bus.d_resp_valid}, {31'd0, ev});
            chk("d_resp_data",  bus.d_resp_data, edata);
        end

        if (r) begin
            pend.delete();
            resq.delete();
            last_if  = 0;
            last_d   = 0;
            m_starve = 0;
        end else begin
            if (resq.size() > 0 && resq[0].cyc == cyc) begin
                rr = resq.pop_front();
                if (rr.is_if) last_if = rr.data;
                else          last_d  = rr.data;
            end
            if (pend.size() > 0 && pend[0].cyc == cyc) begin
                o = pend.pop_front();
                if (o.is_if) begin
                    ea   = {24'd0, o.addr[7:2], 2'b00};
                    rdat = rd(ref_mem[ea[7:0]], ref_mem[ea[7:0] + 8'd1],
                              ref_mem[ea[7:0] + 8'd2], ref_mem[ea[7:0] + 8'd3], WORD, 1'b0);
                end else begin
                    ea   = o.addr;
                    rdat = rd(ref_mem[ea[7:0]], ref_mem[ea[7:0] + 8'd1],
                              ref_mem[ea[7:0] + 8'd2], ref_mem[ea[7:0] + 8'd3], o.rm, o.uns);
                    for (int k = 0; k < nbytes(o.wm); k++)
                        ref_mem[8'(ea[7:0] + k)] = o.wdata[8*k +: 8];
                end
                rr.is_if = o.is_if;
                rr.data  = rdat;
                rr.cyc   = cyc + 1;
                resq.push_back(rr);
            end
            if (e_if || e_d) begin
                o.is_if = e_if;
                o.addr  = e_if ? ia : da;
                o.wdata = dw;
                o.wm    = wm;
                o.rm    = rm;
                o.uns   = u;
                o.cyc   = cyc + 1;
                pend.push_back(o);
            end
            if (!iv || e_if)                  m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
        end

        pw_mode = bus.mem_write_mode;
        pw_addr = bus.mem_address;
        pw_data = bus.mem_data;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, NONE, NONE, 1'b0);
    endtask

    initial begin
        logic [9:0]  mask;
        logic [31:0] saved;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        tb_mem[4] = 8'hDE; tb_mem[5] = 8'hAD; tb_mem[6] = 8'hBE; tb_mem[7] = 8'hEF;
        ref_mem[4] = 8'hDE; ref_mem[5] = 8'hAD; ref_mem[6] = 8'hBE; ref_mem[7] = 8'hEF;

        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, NONE, NONE, 1'b0);
        idle(1);

        // IF fetch of an unaligned address returns the aligned word
        step(1'b0, 1'b0, 1'b1, 32'h6, 1'b0, 32'd0, 32'd0, NONE, NONE, 1'b0);
        idle(2);
        chk("t1_if_data", bus.if_resp_data, 32'hEFBEADDE);

        // Store then signed byte load that must see the store
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 32'h11223344, WORD, NONE, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h13, 32'd0, NONE, BYTE, 1'b0);
        idle(3);
        chk("t2_load", bus.d_resp_data, 32'h00000011);

        // Contention: IF forced in on cycles 5 and 10
        mask = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h40 + 32'(4 * i), 1'b1, 32'h80, 32'd0, NONE, WORD, 1'b0);
            mask[i] = obs_if_rdy;
        end
        chk("t3_pattern", {22'd0, mask}, 32'h210);
        idle(3);

        // IF then D back to back
        step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 32'd0, NONE, NONE, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h24, 32'd0, NONE, HALF, 1'b1);
        idle(3);

        // Store killed by reset while in the issue stage
        saved = {tb_mem[8'h33], tb_mem[8'h32], tb_mem[8'h31], tb_mem[8'h30]};
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h30, 32'hCAFEF00D, WORD, NONE, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, NONE, NONE, 1'b0);
        idle(2);
        chk("t5_mem", {tb_mem[8'h33], tb_mem[8'h32], tb_mem[8'h31], tb_mem[8'h30]}, saved);

        // hold with both valid while a load is in flight
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 32'd0, NONE, WORD, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h14, 32'd0, NONE, WORD, 1'b0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, h, iv, dv, u;
            logic [2:0]  wm, rm;
            logic [31:0] da, dw;
            int          al;
            r  = ($urandom_range(0, 59) == 0);
            h  = ($urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 3) != 0);
            dv = ($urandom_range(0, 3) != 0);
            wm = 3'($urandom_range(0, 3));
            rm = 3'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            al = (nbytes(wm) > nbytes(rm)) ? nbytes(wm) : nbytes(rm);
            if (al == 0) al = 1;
            da = {24'd0, 8'($urandom_range(0, 255))} & ~32'(al - 1);
            dw = $urandom;
            step(r, h, iv, {24'd0, 8'($urandom_range(0, 255))}, dv, da, dw, wm, rm, u);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
